t05_find_least_pair: RTL and testbench
======================================

Name: t05_find_least_pair

Overview:
- Parametrised successor to the team's Huffman least-value finder.
- Scans a frequency/node memory (NUM_LEAF leaf histogram entries, then the first node_cnt internal-node sums) through a req/ack read port.
- Returns the two smallest nonzero entries, their flat indices, their sum and a found count.
- Sits between the histogram SRAM arbiter and the tree-builder FSM. The tree builder issues one start per merge.

Parameters:
- NUM_LEAF, 256, number of leaf (character) entries at flat addresses 0..NUM_LEAF-1.
- NUM_NODE, 128, maximum internal-node entries at flat addresses NUM_LEAF..NUM_LEAF+NUM_NODE-1.
- CNT_W, 64, width of each stored count.
- IDX_W, $clog2(NUM_LEAF+NUM_NODE), derived localparam, flat index width (9 at defaults).
- NC_W, $clog2(NUM_NODE+1), derived localparam, node_cnt width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  begin a scan; honoured only in IDLE.
- node_cnt  in  NC_W  number of valid node entries; sampled on accepted start.
- rd_req  out  1  read request.
- rd_addr  out  IDX_W  flat read address.
- rd_ack  in  1  rd_data valid this cycle; consumes the request.
- rd_data  in  CNT_W  entry value.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse; results valid from this cycle.
- found  out  2  number of nonzero entries captured (0, 1 or 2).
- least1  out  IDX_W  flat index of the smallest entry.
- least2  out  IDX_W  flat index of the second smallest entry.
- least1_node  out  1  least1 >= NUM_LEAF.
- least2_node  out  1  least2 >= NUM_LEAF.
- sum  out  CNT_W+1  val1+val2 when found=2, val1 when found=1, else 0.

Behaviour:
- Reset (synchronous, active-high) drives every output and internal register to 0, and the state to IDLE.
- Reset mid-scan abandons the scan: rd_req=0 and busy=0 on the following cycle, with no done pulse.
- State machine has three states: IDLE, SCAN and FINISH.
- IDLE:
  - start=1 latches lim = NUM_LEAF + min(node_cnt, NUM_NODE).
  - Clears both valid flags, val1 and val2, sets addr=0 and moves to SCAN.
  - start is ignored in every other state.
- SCAN:
  - rd_req=1 and rd_addr=addr, held stable until rd_ack.
  - On rd_ack, rd_data is compared and the tracker updated in the same edge; addr increments.
  - When the acked addr = lim-1, the state moves to FINISH.
  - rd_ack while rd_req=0 is ignored.
- FINISH: done=1 for one cycle, outputs registered, busy falls, state returns to IDLE.
- Latency: with rd_ack tied high, done occurs lim+1 cycles after the start edge. Throughput is one entry per cycle.
- Tracker rules, for each acked value v at index i:
  - v=0 is skipped.
  - else if !valid1 or v < val1: entry 2 takes entry 1, and entry 1 takes (v, i).
  - else if !valid2 or v < val2: entry 2 takes (v, i).
  - Strict less-than, so on ties the lower flat index wins.
  - Valid flags are used in place of an all-ones sentinel, so v = 2^CNT_W-1 is a legal value.
- sum is computed at full CNT_W+1 width, so it never wraps.
- found=0 leaves least1=least2=0. found=1 leaves least2=0 and least2_node=0.
- Results hold until the next FINISH.
- A start asserted in the same cycle as rst is dropped.

Decomposition:
- Package t05_huff_pkg holds:
  - Defaults NUM_LEAF, NUM_NODE and CNT_W.
  - The state enum {IDLE, SCAN, FINISH}.
  - A typedef for the flat index.
- Sub-module t05_min2_tracker holds:
  - The val1/val2/least1/least2/valid registers and the compare-update logic.
  - Inputs: clr, upd, v, i.

Test Plan:
- Leaf minima:
  - Stimulus: mem[65]=5, mem[66]=3, mem[67]=9, all others 0, node_cnt=0, rd_ack tied 1.
  - Response: least1=66, least2=65, sum=8, found=2, both node flags 0, done 257 cycles after start.
- Tie-break:
  - Stimulus: mem[10]=mem[20]=mem[30]=4.
  - Response: least1=10, least2=20, sum=8.
- Node inclusion:
  - Stimulus: node_cnt=2, mem[256]=2, mem[257]=1, mem[5]=7, mem[300]=1 (beyond lim, must not be read).
  - Response: least1=257 with least1_node=1, least2=256, sum=3, highest rd_addr 257.
- Degenerate counts:
  - Stimulus A: only mem[0]=100. Response: found=1, least1=0, sum=100.
  - Stimulus B: all zero. Response: found=0, sum=0.
- Width extremes:
  - Stimulus: mem[1]=mem[2]=2^64-1, node_cnt=200.
  - Response: found=2, sum=2^65-2, lim clamped so the last rd_addr is 383.
- Handshake and reset:
  - Stimulus 1: rd_ack delayed 3 cycles per entry. Required: rd_addr stable while waiting.
  - Stimulus 2: rst at entry 100. Required: rd_req=0 and busy=0 next cycle, no done.
  - Stimulus 3: start re-issued after rst. Required: same result as the leaf-minima scenario.

Source files
------------

// File: rtl/t05_huff_pkg.sv
// Shared definitions for the Huffman least-pair finder: default sizes,
// the scan state encoding and the flat-index type at default sizes.
package t05_huff_pkg;

    localparam int NUM_LEAF_DEF = 256;
    localparam int NUM_NODE_DEF = 128;
    localparam int CNT_W_DEF    = 64;
    localparam int IDX_W_DEF    = $clog2(NUM_LEAF_DEF + NUM_NODE_DEF);

    typedef logic [IDX_W_DEF-1:0] flat_idx_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        FINISH = 2'd2
    } state_e;

endpackage

// File: rtl/t05_min2_tracker.sv
// Keeps the two smallest nonzero values seen since the last clear, with their indices.
// Valid flags replace an all-ones sentinel so the maximum count is a usable value.
module t05_min2_tracker #(
    parameter int CNT_W = 64,
    parameter int IDX_W = 9
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             upd_i,
    input  logic [CNT_W-1:0] v_i,
    input  logic [IDX_W-1:0] i_i,
    output logic             valid1_o,
    output logic             valid2_o,
    output logic [CNT_W-1:0] val1_o,
    output logic [CNT_W-1:0] val2_o,
    output logic [IDX_W-1:0] idx1_o,
    output logic [IDX_W-1:0] idx2_o
);

    logic             valid1_q, valid1_d;
    logic             valid2_q, valid2_d;
    logic [CNT_W-1:0] val1_q, val1_d;
    logic [CNT_W-1:0] val2_q, val2_d;
    logic [IDX_W-1:0] idx1_q, idx1_d;
    logic [IDX_W-1:0] idx2_q, idx2_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid1_q <= 1'b0;
            valid2_q <= 1'b0;
            val1_q   <= '0;
            val2_q   <= '0;
            idx1_q   <= '0;
            idx2_q   <= '0;
        end else begin
            valid1_q <= valid1_d;
            valid2_q <= valid2_d;
            val1_q   <= val1_d;
            val2_q   <= val2_d;
            idx1_q   <= idx1_d;
            idx2_q   <= idx2_d;
        end
    end

    // Strict less-than keeps the earlier (lower) index on ties.
    always_comb begin
        valid1_d = valid1_q;
        valid2_d = valid2_q;
        val1_d   = val1_q;
        val2_d   = val2_q;
        idx1_d   = idx1_q;
        idx2_d   = idx2_q;
        if (clr_i) begin
            valid1_d = 1'b0;
            valid2_d = 1'b0;
            val1_d   = '0;
            val2_d   = '0;
            idx1_d   = '0;
            idx2_d   = '0;
        end else if (upd_i && (v_i != '0)) begin
            if (!valid1_q || (v_i < val1_q)) begin
                valid2_d = valid1_q;
                val2_d   = val1_q;
                idx2_d   = idx1_q;
                valid1_d = 1'b1;
                val1_d   = v_i;
                idx1_d   = i_i;
            end else if (!valid2_q || (v_i < val2_q)) begin
                valid2_d = 1'b1;
                val2_d   = v_i;
                idx2_d   = i_i;
            end
        end
    end

    assign valid1_o = valid1_q;
    assign valid2_o = valid2_q;
    assign val1_o   = val1_q;
    assign val2_o   = val2_q;
    assign idx1_o   = idx1_q;
    assign idx2_o   = idx2_q;

endmodule

// File: rtl/t05_find_least_pair.sv
// Scans leaf entries plus the active internal nodes through a req/ack port and
// reports the two smallest nonzero counts, their flat indices and their sum.
module t05_find_least_pair
    import t05_huff_pkg::*;
#(
    parameter int NUM_LEAF = NUM_LEAF_DEF,
    parameter int NUM_NODE = NUM_NODE_DEF,
    parameter int CNT_W    = CNT_W_DEF,
    localparam int IDX_W   = $clog2(NUM_LEAF + NUM_NODE),
    localparam int NC_W    = $clog2(NUM_NODE + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [NC_W-1:0]  node_cnt_i,
    output logic             rd_req_o,
    output logic [IDX_W-1:0] rd_addr_o,
    input  logic             rd_ack_i,
    input  logic [CNT_W-1:0] rd_data_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [1:0]       found_o,
    output logic [IDX_W-1:0] least1_o,
    output logic [IDX_W-1:0] least2_o,
    output logic             least1_node_o,
    output logic             least2_node_o,
    output logic [CNT_W:0]   sum_o
);

    // One extra bit so a limit equal to the full address space still fits.
    localparam int LIM_W = IDX_W + 1;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] addr_q, addr_d;
    logic [LIM_W-1:0] lim_q, lim_d;
    logic             done_q, done_d;
    logic [1:0]       found_q, found_d;
    logic [IDX_W-1:0] least1_q, least1_d;
    logic [IDX_W-1:0] least2_q, least2_d;
    logic             least1_node_q, least1_node_d;
    logic             least2_node_q, least2_node_d;
    logic [CNT_W:0]   sum_q, sum_d;

    logic             tr_clr;
    logic             tr_upd;
    logic             tr_valid1, tr_valid2;
    logic [CNT_W-1:0] tr_val1, tr_val2;
    logic [IDX_W-1:0] tr_idx1, tr_idx2;

    logic [LIM_W-1:0] node_clamp;
    logic             last_entry;

    assign node_clamp = (32'(node_cnt_i) > 32'(NUM_NODE)) ? LIM_W'(NUM_NODE)
                                                          : LIM_W'(node_cnt_i);
    assign last_entry = ({1'b0, addr_q} == (lim_q - LIM_W'(1)));
    assign tr_upd     = (state_q == SCAN) && rd_ack_i;

    t05_min2_tracker #(
        .CNT_W (CNT_W),
        .IDX_W (IDX_W)
    ) u_tracker (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .clr_i    (tr_clr),
        .upd_i    (tr_upd),
        .v_i      (rd_data_i),
        .i_i      (addr_q),
        .valid1_o (tr_valid1),
        .valid2_o (tr_valid2),
        .val1_o   (tr_val1),
        .val2_o   (tr_val2),
        .idx1_o   (tr_idx1),
        .idx2_o   (tr_idx2)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            addr_q        <= '0;
            lim_q         <= '0;
            done_q        <= 1'b0;
            found_q       <= 2'd0;
            least1_q      <= '0;
            least2_q      <= '0;
            least1_node_q <= 1'b0;
            least2_node_q <= 1'b0;
            sum_q         <= '0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            lim_q         <= lim_d;
            done_q        <= done_d;
            found_q       <= found_d;
            least1_q      <= least1_d;
            least2_q      <= least2_d;
            least1_node_q <= least1_node_d;
            least2_node_q <= least2_node_d;
            sum_q         <= sum_d;
        end
    end

    // Results are captured in FINISH, after the last ack has settled the tracker.
    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        lim_d         = lim_q;
        done_d        = 1'b0;
        found_d       = found_q;
        least1_d      = least1_q;
        least2_d      = least2_q;
        least1_node_d = least1_node_q;
        least2_node_d = least2_node_q;
        sum_d         = sum_q;
        tr_clr        = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    lim_d   = LIM_W'(NUM_LEAF) + node_clamp;
                    addr_d  = '0;
                    tr_clr  = 1'b1;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (rd_ack_i) begin
                    addr_d = addr_q + IDX_W'(1);
                    if (last_entry) begin
                        state_d = FINISH;
                    end
                end
            end
            FINISH: begin
                done_d        = 1'b1;
                found_d       = tr_valid2 ? 2'd2 : (tr_valid1 ? 2'd1 : 2'd0);
                least1_d      = tr_valid1 ? tr_idx1 : '0;
                least2_d      = tr_valid2 ? tr_idx2 : '0;
                least1_node_d = tr_valid1 && (32'(tr_idx1) >= 32'(NUM_LEAF));
                least2_node_d = tr_valid2 && (32'(tr_idx2) >= 32'(NUM_LEAF));
                if (tr_valid2) begin
                    sum_d = {1'b0, tr_val1} + {1'b0, tr_val2};
                end else if (tr_valid1) begin
                    sum_d = {1'b0, tr_val1};
                end else begin
                    sum_d = '0;
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign rd_req_o      = (state_q == SCAN);
    assign rd_addr_o     = addr_q;
    assign busy_o        = (state_q != IDLE);
    assign done_o        = done_q;
    assign found_o       = found_q;
    assign least1_o      = least1_q;
    assign least2_o      = least2_q;
    assign least1_node_o = least1_node_q;
    assign least2_node_o = least2_node_q;
    assign sum_o         = sum_q;

endmodule

// File: tb/tb_t05_find_least_pair.sv
// Directed bench for t05_find_least_pair: a memory model answers the read port,
// and each scenario's result is compared against hand-computed values.
module tb_t05_find_least_pair;

    localparam int MEM_N = 384;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  node_cnt;
    logic        rd_req;
    logic [8:0]  rd_addr;
    logic        rd_ack;
    logic [63:0] rd_data;
    logic        busy;
    logic        done;
    logic [1:0]  found;
    logic [8:0]  least1;
    logic [8:0]  least2;
    logic        least1_node;
    logic        least2_node;
    logic [64:0] sum;

    logic [63:0] mem [0:MEM_N-1];

    int   testCount = 0;
    int   failCount = 0;
    int   maxAddr   = 0;
    int   doneCount = 0;
    int   waitCnt   = 0;
    int   cycles    = 0;
    logic ackMode   = 1'b0;
    logic ackDly    = 1'b0;
    logic prevWait  = 1'b0;
    logic [8:0] prevAddr = '0;
    logic addrMoved = 1'b0;

    t05_find_least_pair dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .start_i       (start),
        .node_cnt_i    (node_cnt),
        .rd_req_o      (rd_req),
        .rd_addr_o     (rd_addr),
        .rd_ack_i      (rd_ack),
        .rd_data_i     (rd_data),
        .busy_o        (busy),
        .done_o        (done),
        .found_o       (found),
        .least1_o      (least1),
        .least2_o      (least2),
        .least1_node_o (least1_node),
        .least2_node_o (least2_node),
        .sum_o         (sum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign rd_ack  = ackMode ? ackDly : 1'b1;
    assign rd_data = (int'(rd_addr) < MEM_N) ? mem[rd_addr] : 64'd0;

    // Memory-side monitor: delayed-ack generator, address stability, highest address read, done pulses.
    always @(negedge clk) begin
        if (done === 1'b1) doneCount++;
        if (rd_req && rd_ack && (int'(rd_addr) > maxAddr)) maxAddr = int'(rd_addr);
        if (ackMode) begin
            if (prevWait && rd_req && (rd_addr !== prevAddr)) addrMoved = 1'b1;
            if (rd_req) begin
                if (ackDly) begin
                    ackDly  = 1'b0;
                    waitCnt = 0;
                end else if (waitCnt == 2) begin
                    ackDly = 1'b1;
                end else begin
                    waitCnt++;
                end
            end else begin
                ackDly  = 1'b0;
                waitCnt = 0;
            end
            prevWait = rd_req && !ackDly;
            prevAddr = rd_addr;
        end else begin
            ackDly   = 1'b0;
            prevWait = 1'b0;
        end
    end

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        testCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clearMem();
        for (int k = 0; k < MEM_N; k++) mem[k] = 64'd0;
    endtask

    task automatic applyStimulus(input int nodeCnt, output int nCycles);
        @(negedge clk);
        maxAddr  = 0;
        start    = 1'b1;
        node_cnt = nodeCnt[7:0];
        @(posedge clk);
        #1;
        start   = 1'b0;
        nCycles = 0;
        for (int k = 0; k < 3000; k++) begin
            @(posedge clk);
            #1;
            nCycles++;
            if (done === 1'b1) break;
        end
        checkOutput("doneSeen", {127'd0, done}, 128'd1);
    endtask

    task automatic loadLeafMinima();
        clearMem();
        mem[65] = 64'd5;
        mem[66] = 64'd3;
        mem[67] = 64'd9;
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        node_cnt = 8'd0;
        clearMem();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("rstBusy",  {127'd0, busy},   128'd0);
        checkOutput("rstDone",  {127'd0, done},   128'd0);
        checkOutput("rstReq",   {127'd0, rd_req}, 128'd0);
        checkOutput("rstFound", {126'd0, found},  128'd0);
        checkOutput("rstSum",   {63'd0, sum},     128'd0);
        checkOutput("rstAddr",  {119'd0, rd_addr}, 128'd0);

        $display("[TB] leaf minima");
        loadLeafMinima();
        applyStimulus(0, cycles);
        checkOutput("leafLatency", 128'(cycles), 128'd257);
        checkOutput("leafL1",    {119'd0, least1}, 128'd66);
        checkOutput("leafL2",    {119'd0, least2}, 128'd65);
        checkOutput("leafSum",   {63'd0, sum},     128'd8);
        checkOutput("leafFound", {126'd0, found},  128'd2);
        checkOutput("leafN1",    {127'd0, least1_node}, 128'd0);
        checkOutput("leafN2",    {127'd0, least2_node}, 128'd0);
        checkOutput("leafBusy",  {127'd0, busy},   128'd0);
        checkOutput("leafMaxA",  128'(maxAddr),    128'd255);
        @(posedge clk);
        #1;
        checkOutput("donePulse", {127'd0, done},   128'd0);
        checkOutput("leafHold",  {119'd0, least1}, 128'd66);

        $display("[TB] tie-break");
        clearMem();
        mem[10] = 64'd4;
        mem[20] = 64'd4;
        mem[30] = 64'd4;
        applyStimulus(0, cycles);
        checkOutput("tieL1",  {119'd0, least1}, 128'd10);
        checkOutput("tieL2",  {119'd0, least2}, 128'd20);
        checkOutput("tieSum", {63'd0, sum},     128'd8);

        $display("[TB] node inclusion");
        clearMem();
        mem[256] = 64'd2;
        mem[257] = 64'd1;
        mem[5]   = 64'd7;
        mem[300] = 64'd1;
        applyStimulus(2, cycles);
        checkOutput("nodeLatency", 128'(cycles), 128'd259);
        checkOutput("nodeL1",  {119'd0, least1}, 128'd257);
        checkOutput("nodeN1",  {127'd0, least1_node}, 128'd1);
        checkOutput("nodeL2",  {119'd0, least2}, 128'd256);
        checkOutput("nodeN2",  {127'd0, least2_node}, 128'd1);
        checkOutput("nodeSum", {63'd0, sum},     128'd3);
        checkOutput("nodeMaxA", 128'(maxAddr),   128'd257);

        $display("[TB] single nonzero");
        clearMem();
        mem[0] = 64'd100;
        applyStimulus(0, cycles);
        checkOutput("oneFound", {126'd0, found},  128'd1);
        checkOutput("oneL1",    {119'd0, least1}, 128'd0);
        checkOutput("oneL2",    {119'd0, least2}, 128'd0);
        checkOutput("oneN2",    {127'd0, least2_node}, 128'd0);
        checkOutput("oneSum",   {63'd0, sum},     128'd100);

        $display("[TB] all zero");
        clearMem();
        applyStimulus(0, cycles);
        checkOutput("zeroFound", {126'd0, found},  128'd0);
        checkOutput("zeroSum",   {63'd0, sum},     128'd0);
        checkOutput("zeroL1",    {119'd0, least1}, 128'd0);

        $display("[TB] width extremes");
        clearMem();
        mem[1] = '1;
        mem[2] = '1;
        applyStimulus(200, cycles);
        checkOutput("wideFound", {126'd0, found},  128'd2);
        checkOutput("wideSum",   {63'd0, sum},     (128'd1 << 65) - 128'd2);
        checkOutput("wideL1",    {119'd0, least1}, 128'd1);
        checkOutput("wideL2",    {119'd0, least2}, 128'd2);
        checkOutput("wideMaxA",  128'(maxAddr),    128'd383);
        checkOutput("wideLatency", 128'(cycles),   128'd385);

        $display("[TB] delayed ack");
        loadLeafMinima();
        addrMoved = 1'b0;
        ackMode   = 1'b1;
        applyStimulus(0, cycles);
        ackMode   = 1'b0;
        checkOutput("dlyStable", {127'd0, addrMoved}, 128'd0);
        checkOutput("dlyL1",     {119'd0, least1},    128'd66);
        checkOutput("dlyL2",     {119'd0, least2},    128'd65);
        checkOutput("dlySum",    {63'd0, sum},        128'd8);
        checkOutput("dlySlow",   128'(cycles > 700),  128'd1);

        $display("[TB] reset mid-scan");
        @(negedge clk);
        start = 1'b1;
        node_cnt = 8'd0;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 400; k++) begin
            if (rd_addr == 9'd100) break;
            @(negedge clk);
        end
        checkOutput("midReached", {119'd0, rd_addr}, 128'd100);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("midReq",   {127'd0, rd_req}, 128'd0);
        checkOutput("midBusy",  {127'd0, busy},   128'd0);
        checkOutput("midFound", {126'd0, found},  128'd0);
        @(negedge clk);
        rst = 1'b0;
        doneCount = 0;
        repeat (300) @(posedge clk);
        #1;
        checkOutput("midNoDone", 128'(doneCount), 128'd0);

        $display("[TB] start during reset");
        @(negedge clk);
        rst   = 1'b1;
        start = 1'b1;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("rstStartBusy", {127'd0, busy},   128'd0);
        checkOutput("rstStartReq",  {127'd0, rd_req}, 128'd0);

        $display("[TB] restart after reset");
        applyStimulus(0, cycles);
        checkOutput("reLatency", 128'(cycles),      128'd257);
        checkOutput("reL1",      {119'd0, least1},  128'd66);
        checkOutput("reL2",      {119'd0, least2},  128'd65);
        checkOutput("reSum",     {63'd0, sum},      128'd8);
        checkOutput("reFound",   {126'd0, found},   128'd2);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
